// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: tap sequencer and multiply-accumulate stage for a direct-form FIR.
// Define FIR_SATURATE_EN to clamp results to DATA_WIDTH; otherwise the low bits wrap.
module fir_mac_sequencer #(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH      = 32,
    parameter int FRAC_BITS       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH-1:0]      h_addr,
    output logic [DATA_ADDR_WIDTH-1:0] x_addr,
    output logic                       R_en,
    input  logic [DATA_WIDTH-1:0]      h_in,
    input  logic [DATA_WIDTH-1:0]      x_in,
    output logic [DATA_WIDTH-1:0]      y_out,
    output logic [DATA_ADDR_WIDTH-1:0] y_index,
    output logic                       y_valid,
    input  logic                       y_ready
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUTPUT,
        DONE
    } state_t;

    state_t                      state;
    logic [DATA_ADDR_WIDTH-1:0]  n;
    logic [ADDR_WIDTH-1:0]       k;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        tap_valid;

    logic signed [PROD_WIDTH-1:0] h_ext;
    logic signed [PROD_WIDTH-1:0] x_ext;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic [DATA_WIDTH-1:0]        y_conv;
    logic [ADDR_WIDTH-1:0]        k_inc;
    logic [DATA_ADDR_WIDTH-1:0]   k_inc_ext;
    logic [DATA_ADDR_WIDTH-1:0]   n_inc;
    logic                         last_tap;
    logic                         last_sample;

    // Operands are sign-extended so the truncated product is the exact signed product.
    assign h_ext = {{DATA_WIDTH{h_in[DATA_WIDTH-1]}}, h_in};
    assign x_ext = {{DATA_WIDTH{x_in[DATA_WIDTH-1]}}, x_in};
    assign prod  = h_ext * x_ext;

    assign acc_next = tap_valid
                    ? acc + {{ADDR_WIDTH{prod[PROD_WIDTH-1]}}, prod}
                    : acc;

    assign k_inc       = k + ADDR_WIDTH'(1);
    assign k_inc_ext   = DATA_ADDR_WIDTH'(k_inc);
    assign n_inc       = n + DATA_ADDR_WIDTH'(1);
    assign last_tap    = &k;
    assign last_sample = &n;

`ifdef FIR_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] Y_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc_shift;

    assign acc_shift = acc_next >>> FRAC_BITS;

    always_comb begin
        y_conv = acc_shift[DATA_WIDTH-1:0];
        if (acc_shift > Y_MAX) begin
            y_conv = Y_MAX[DATA_WIDTH-1:0];
        end else if (acc_shift < Y_MIN) begin
            y_conv = Y_MIN[DATA_WIDTH-1:0];
        end
    end
`else
    // Wrapping keeps only the bits an arithmetic shift would land in the output.
    assign y_conv = acc_next[FRAC_BITS +: DATA_WIDTH];
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            n         <= '0;
            k         <= '0;
            acc       <= '0;
            tap_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            h_addr    <= '0;
            x_addr    <= '0;
            R_en      <= 1'b0;
            y_out     <= '0;
            y_index   <= '0;
            y_valid   <= 1'b0;
        end else begin
            tap_valid <= R_en;
            acc       <= acc_next;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= FETCH;
                        busy   <= 1'b1;
                        n      <= '0;
                        k      <= '0;
                        acc    <= '0;
                        h_addr <= '0;
                        x_addr <= '0;
                        R_en   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (last_tap) begin
                        state <= DRAIN;
                        R_en  <= 1'b0;
                    end else begin
                        k      <= k_inc;
                        h_addr <= k_inc;
                        x_addr <= n - k_inc_ext;
                        R_en   <= (k_inc_ext <= n);
                    end
                end
                DRAIN: begin
                    state   <= OUTPUT;
                    y_out   <= y_conv;
                    y_index <= n;
                    y_valid <= 1'b1;
                end
                OUTPUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        if (last_sample) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= FETCH;
                            n      <= n_inc;
                            k      <= '0;
                            acc    <= '0;
                            h_addr <= '0;
                            x_addr <= n_inc;
                            R_en   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: randomized and directed checks of fir_mac_sequencer
// against a direct convolution model fed through a registered ROM model.
module tb_fir_mac_sequencer;

    localparam int AW  = 4;
    localparam int DAW = 6;
    localparam int DW  = 32;
    localparam int FB  = 16;
    localparam int NT  = 1 << AW;
    localparam int NS  = 1 << DAW;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           busy;
    logic           done;
    logic [AW-1:0]  h_addr;
    logic [DAW-1:0] x_addr;
    logic           R_en;
    logic [DW-1:0]  h_in;
    logic [DW-1:0]  x_in;
    logic [DW-1:0]  y_out;
    logic [DAW-1:0] y_index;
    logic           y_valid;
    logic           y_ready;

    int tests;
    int fails;

    logic [DW-1:0]  h_mem [NT];
    logic [DW-1:0]  x_mem [NS];
    logic [DW-1:0]  exp_y [NS];

    logic [DW-1:0]  got_y   [NS];
    logic [DAW-1:0] got_idx [NS];
    int             acc_cyc [NS];
    logic [DW-1:0]  stall_y [5];
    logic [DAW-1:0] stall_i [5];
    int nres, ren_cnt, done_cnt, lat_first, done_cyc;
    int addr_err, timeout, stall_cnt, busy_after_done;
    logic           snap_ren;
    logic [AW-1:0]  snap_h;
    logic [DAW-1:0] snap_x;

    fir_mac_sequencer #(
        .ADDR_WIDTH     (AW),
        .DATA_ADDR_WIDTH(DAW),
        .DATA_WIDTH     (DW),
        .FRAC_BITS      (FB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .h_addr (h_addr),
        .x_addr (x_addr),
        .R_en   (R_en),
        .h_in   (h_in),
        .x_in   (x_in),
        .y_out  (y_out),
        .y_index(y_index),
        .y_valid(y_valid),
        .y_ready(y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM read port
    always @(posedge clk) begin
        if (R_en) begin
            h_in <= h_mem[h_addr];
            x_in <= x_mem[x_addr];
        end
    end

    function automatic void build_model();
        for (int nn = 0; nn < NS; nn++) begin
            logic signed [67:0] s;
            logic signed [67:0] q;
            logic signed [67:0] hv;
            logic signed [67:0] xv;
            s = '0;
            for (int kk = 0; kk < NT; kk++) begin
                if (kk <= nn) begin
                    hv = 68'($signed(h_mem[kk]));
                    xv = 68'($signed(x_mem[nn-kk]));
                    s  = s + hv * xv;
                end
            end
            q = s >>> FB;
`ifdef FIR_SATURATE_EN
            if (q > 68'sh7FFFFFFF)
                exp_y[nn] = 32'h7FFFFFFF;
            else if (q < -68'sh80000000)
                exp_y[nn] = 32'h80000000;
            else
                exp_y[nn] = q[31:0];
`else
            exp_y[nn] = q[31:0];
`endif
        end
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < NT; i++) h_mem[i] = 32'h0001_0000;
        for (int i = 0; i < NS; i++) x_mem[i] = DW'(i);
        build_model();
    endtask

    // Runs one pass; mode 0 = ready high, 1 = random ready, 2 = stall at n=3
    task automatic run_pass(input int mode, input bit spam);
        int cyc;
        bit fin;
        nres = 0; ren_cnt = 0; done_cnt = 0; lat_first = -1;
        done_cyc = -1; addr_err = 0; timeout = 0; stall_cnt = 0;
        busy_after_done = -1; snap_ren = 1'b0; snap_h = '1; snap_x = '1;
        for (int i = 0; i < NS; i++) begin
            got_y[i] = 32'hDEAD_BEEF;
            got_idx[i] = '1;
            acc_cyc[i] = -100;
        end
        start = 1'b1;
        y_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        fin = 1'b0;
        while (!fin) begin
            if (R_en) begin
                ren_cnt++;
                if (int'(h_addr) > nres) addr_err++;
                if (x_addr != DAW'(nres - int'(h_addr))) addr_err++;
            end
            if (y_valid && lat_first < 0) lat_first = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after_done = int'(busy);
            if (nres == 4 && cyc == acc_cyc[3] + 1) begin
                snap_ren = R_en;
                snap_h = h_addr;
                snap_x = x_addr;
            end
            start = (spam && busy && !done && done_cnt == 0)
                  ? 1'($urandom_range(0, 1)) : 1'b0;
            case (mode)
                0: y_ready = 1'b1;
                1: y_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (y_valid && y_index == 3 && stall_cnt < 5) begin
                        stall_y[stall_cnt] = y_out;
                        stall_i[stall_cnt] = y_index;
                        stall_cnt++;
                        y_ready = 1'b0;
                    end else begin
                        y_ready = 1'b1;
                    end
                end
            endcase
            if (y_valid && y_ready && nres < NS) begin
                got_y[nres] = y_out;
                got_idx[nres] = y_index;
                acc_cyc[nres] = cyc;
                nres++;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1'b1;
            else if (cyc > 4000) begin
                timeout = 1;
                fin = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        y_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b1;
        y_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, R_en, y_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 0000", {busy, done, R_en, y_valid});
        end
        tests++;
        if (h_addr !== '0 || x_addr !== '0 || y_out !== '0 || y_index !== '0) begin
            fails++;
            $display("FAIL reset_data: got %0h/%0h/%0h/%0h required 0", h_addr, x_addr, y_out, y_index);
        end
        start = 1'b0;
        y_ready = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy %b required 0", busy);
        end
    endtask

    task automatic test_ramp();
        int cn [6] = '{0, 1, 3, 15, 20, 63};
        int cv [6] = '{0, 1, 6, 120, 200, 888};
        load_ramp();
        run_pass(0, 1'b0);
        tests++;
        if (timeout != 0 || nres != NS) begin
            fails++;
            $display("FAIL ramp_count: got %0d results timeout %0d required 64", nres, timeout);
        end
        tests++;
        if (lat_first != 18) begin
            fails++;
            $display("FAIL ramp_latency: got %0d required 18", lat_first);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (got_y[cn[i]] !== DW'(cv[i])) begin
                fails++;
                $display("FAIL ramp_const y[%0d]: got %0d required %0d", cn[i], got_y[cn[i]], cv[i]);
            end
        end
        for (int i = 0; i < NS; i++) begin
            tests++;
            if (got_y[i] !== exp_y[i] || got_idx[i] !== DAW'(i)) begin
                fails++;
                $display("FAIL ramp_y[%0d]: got %0h idx %0d required %0h idx %0d", i, got_y[i], got_idx[i], exp_y[i], i);
            end
        end
        tests++;
        if (acc_cyc[NS-1] != NS * 18 || done_cyc != NS * 18 + 1) begin
            fails++;
            $display("FAIL ramp_pass_len: last accept %0d done %0d required 1152 1153", acc_cyc[NS-1], done_cyc);
        end
        tests++;
        if (done_cnt != 1 || busy_after_done != 0) begin
            fails++;
            $display("FAIL ramp_done: pulses %0d busy_after %0d required 1 0", done_cnt, busy_after_done);
        end
    endtask

    task automatic test_impulse();
        for (int i = 0; i < NT; i++) h_mem[i] = DW'(i + 1);
        for (int i = 0; i < NS; i++) x_mem[i] = '0;
        x_mem[0] = 32'h0001_0000;
        build_model();
        run_pass(0, 1'b0);
        for (int i = 0; i < NS; i++) begin
            tests++;
            if (got_y[i] !== ((i < NT) ? DW'(i + 1) : '0) || got_y[i] !== exp_y[i]) begin
                fails++;
                $display("FAIL impulse_y[%0d]: got %0h required %0h", i, got_y[i], exp_y[i]);
            end
        end
        tests++;
        if (ren_cnt != 904) begin
            fails++;
            $display("FAIL impulse_ren_count: got %0d required 904", ren_cnt);
        end
        tests++;
        if (addr_err != 0) begin
            fails++;
            $display("FAIL impulse_addr: got %0d bad read cycles required 0", addr_err);
        end
    endtask

    task automatic test_backpressure();
        load_ramp();
        run_pass(2, 1'b0);
        tests++;
        if (stall_cnt != 5) begin
            fails++;
            $display("FAIL bp_stall_cycles: got %0d required 5", stall_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (stall_y[i] !== 32'd6 || stall_i[i] !== 6'd3) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got y %0d idx %0d required 6 3", i, stall_y[i], stall_i[i]);
            end
        end
        tests++;
        if (snap_ren !== 1'b1 || snap_h !== 4'd0 || snap_x !== 6'd4) begin
            fails++;
            $display("FAIL bp_next_fetch: got ren %b h %0d x %0d required 1 0 4", snap_ren, snap_h, snap_x);
        end
        for (int i = 0; i < NS; i++) begin
            tests++;
            if (got_y[i] !== exp_y[i] || got_idx[i] !== DAW'(i)) begin
                fails++;
                $display("FAIL bp_y[%0d]: got %0h required %0h", i, got_y[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] want;
        for (int i = 0; i < NT; i++) h_mem[i] = '0;
        for (int i = 0; i < NS; i++) x_mem[i] = '0;
        h_mem[0] = 32'h7FFF_FFFF;
        x_mem[0] = 32'h7FFF_FFFF;
        build_model();
`ifdef FIR_SATURATE_EN
        want = 32'h7FFF_FFFF;
`else
        want = 32'hFFFF_0000;
`endif
        run_pass(0, 1'b0);
        tests++;
        if (got_y[0] !== want) begin
            fails++;
            $display("FAIL overflow_y0: got %0h required %0h", got_y[0], want);
        end
        for (int i = 1; i < NS; i++) begin
            tests++;
            if (got_y[i] !== exp_y[i]) begin
                fails++;
                $display("FAIL overflow_y[%0d]: got %0h required %0h", i, got_y[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < NT; i++) h_mem[i] = $urandom;
        for (int i = 0; i < NS; i++) x_mem[i] = $urandom;
        build_model();
        run_pass(1, 1'b0);
        tests++;
        if (timeout != 0 || nres != NS || done_cnt != 1) begin
            fails++;
            $display("FAIL rand_pass: got %0d results %0d done timeout %0d required 64 1 0", nres, done_cnt, timeout);
        end
        for (int i = 0; i < NS; i++) begin
            tests++;
            if (got_y[i] !== exp_y[i] || got_idx[i] !== DAW'(i)) begin
                fails++;
                $display("FAIL rand_y[%0d]: got %0h idx %0d required %0h idx %0d", i, got_y[i], got_idx[i], exp_y[i], i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        bit hit;
        bit saw_done;
        load_ramp();
        cnt = 0;
        hit = 1'b0;
        saw_done = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        y_ready = 1'b1;
        for (int c = 0; c < 600 && !hit; c++) begin
            if (done) saw_done = 1'b1;
            if (cnt == 5 && busy && !y_valid && h_addr == 4'd7) begin
                hit = 1'b1;
            end else begin
                if (y_valid && y_ready) cnt++;
                @(posedge clk); #1;
            end
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL rstmid_reach: never reached n=5 k=7 (accepted %0d)", cnt);
        end
        tests++;
        if (R_en !== 1'b0 || x_addr !== 6'd62) begin
            fails++;
            $display("FAIL rstmid_tap: got ren %b x %0d required 0 62", R_en, x_addr);
        end
        #2 rst_n = 1'b1;
        #1;
        tests++;
        if ({busy, done, R_en, y_valid} !== 4'b0000 || h_addr !== '0 || x_addr !== '0
            || y_out !== '0 || y_index !== '0) begin
            fails++;
            $display("FAIL rstmid_async: got ctrl %b h %0d x %0d y %0h idx %0d required all 0",
                     {busy, done, R_en, y_valid}, h_addr, x_addr, y_out, y_index);
        end
        y_ready = 1'b0;
        @(posedge clk); #1;
        #3 rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || saw_done) begin
            fails++;
            $display("FAIL rstmid_idle: busy %b done %b saw_done %b required 0 0 0", busy, done, saw_done);
        end
        run_pass(0, 1'b0);
        tests++;
        if (lat_first != 18 || got_idx[0] !== 6'd0 || got_y[0] !== exp_y[0]) begin
            fails++;
            $display("FAIL rstmid_restart: lat %0d idx %0d y %0h required 18 0 %0h", lat_first, got_idx[0], got_y[0], exp_y[0]);
        end
        tests++;
        if (got_y[1] !== 32'd1 || got_y[3] !== 32'd6 || got_y[63] !== 32'd888 || done_cnt != 1) begin
            fails++;
            $display("FAIL rstmid_pass: y1 %0d y3 %0d y63 %0d done %0d required 1 6 888 1", got_y[1], got_y[3], got_y[63], done_cnt);
        end
    endtask

    task automatic test_control();
        for (int i = 0; i < NT; i++) h_mem[i] = $urandom_range(0, 32'h3FFFF) - 32'h20000;
        for (int i = 0; i < NS; i++) x_mem[i] = $urandom_range(0, 32'h3FFFF) - 32'h20000;
        build_model();
        run_pass(1, 1'b1);
        tests++;
        if (nres != NS || timeout != 0) begin
            fails++;
            $display("FAIL ctrl_count: got %0d results timeout %0d required 64 0", nres, timeout);
        end
        tests++;
        if (done_cnt != 1 || done_cyc != acc_cyc[NS-1] + 1) begin
            fails++;
            $display("FAIL ctrl_done: pulses %0d at %0d required 1 at %0d", done_cnt, done_cyc, acc_cyc[NS-1] + 1);
        end
        tests++;
        if (busy_after_done != 0 || ren_cnt != 904 || addr_err != 0) begin
            fails++;
            $display("FAIL ctrl_seq: busy_after %0d ren %0d addr_err %0d required 0 904 0", busy_after_done, ren_cnt, addr_err);
        end
        for (int i = 0; i < NS; i++) begin
            tests++;
            if (got_y[i] !== exp_y[i] || got_idx[i] !== DAW'(i)) begin
                fails++;
                $display("FAIL ctrl_y[%0d]: got %0h required %0h", i, got_y[i], exp_y[i]);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        start = 1'b0;
        y_ready = 1'b0;
        rst_n = 1'b1;
        test_reset();
        test_ramp();
        test_impulse();
        test_backpressure();
        test_overflow();
        test_random();
        test_reset_mid();
        test_control();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Sequencer and multiply-accumulate stage that drives the coefficient/sample ROM's read port and consumes its registered `h_out`/`x_out` data. It computes a direct-form FIR result for every sample address. It emits each result over a valid/ready handshake to the downstream sink. It sits directly between the ROM and the FIR output/writeback logic.

## Interface
- `ADDR_WIDTH`, 4: coefficient address width; NUM_TAPS = 1<<ADDR_WIDTH.
- `DATA_ADDR_WIDTH`, 6: sample address width; NUM_SAMPLES = 1<<DATA_ADDR_WIDTH.
- `DATA_WIDTH`, 32: signed two's-complement width of coefficients, samples and `y_out`.
- `FRAC_BITS`, 16: arithmetic right shift applied to the accumulator before output.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-high (asserted = 1), despite the name.
- `start` in 1: begin a full pass; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last result is accepted.
- `h_addr` out ADDR_WIDTH: coefficient index k.
- `x_addr` out DATA_ADDR_WIDTH: sample index n-k.
- `R_en` out 1: ROM read enable.
- `h_in` in DATA_WIDTH: ROM `h_out`, valid one cycle after `R_en`.
- `x_in` in DATA_WIDTH: ROM `x_out`, valid one cycle after `R_en`.
- `y_out` out DATA_WIDTH: result for sample `y_index`.
- `y_index` out DATA_ADDR_WIDTH: n of the current result.
- `y_valid` out 1: result available.
- `y_ready` in 1: sink accepts the result.

## Operation
- All outputs are registered. Reset forces IDLE; every output is 0; n, k, the accumulator and the pipeline valid bit are cleared.
- FSM states are IDLE, FETCH, DRAIN, OUTPUT and DONE.
- **IDLE**: `start`=1 → FETCH with n=0, k=0, acc=0.
- **FETCH** issues one tap per cycle:
  - `h_addr`=k and `x_addr`=(n-k) mod NUM_SAMPLES.
  - `R_en`=1 only when k≤n. Taps with k>n still take a cycle, hold `R_en`=0 and contribute zero.
  - After k=NUM_TAPS-1 → DRAIN.
- **Pipeline**: a one-cycle delayed tap-valid bit tracks each read. On the cycle after an issued read, acc += signed(h_in)·signed(x_in).
- **Accumulator width**: ACC_WIDTH = 2·DATA_WIDTH+ADDR_WIDTH. It is sign-extended and cannot overflow.
- **DRAIN**: absorbs the final product, then → OUTPUT. `R_en`=0.
- **OUTPUT**:
  - `y_out` = output conversion of (acc >>> FRAC_BITS), and `y_valid`=1.
  - `y_out` and `y_index` are held stable while `y_ready`=0.
  - On `y_valid`&`y_ready`: if n=NUM_SAMPLES-1 → DONE; else n++, k=0, acc=0 → FETCH.
- **DONE**: `done`=1 for one cycle → IDLE.
- `start` while `busy` is ignored.
- `y_ready` outside OUTPUT is ignored.
- Asynchronous reset mid-pass aborts immediately; no partial result or `done` is emitted.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: first FETCH cycle; `R_en`/addresses for k=0 are presented.
- Cycles 1..NUM_TAPS: FETCH. Cycle NUM_TAPS+1: DRAIN. Cycle NUM_TAPS+2: first `y_valid`.
- With `y_ready` tied high, each sample takes NUM_TAPS+2 cycles. For the defaults a full pass is 64·18 cycles, plus one `done` cycle.
- Within a sample, the product of tap k is accumulated on the cycle after tap k is issued.

## Configuration
- `FIR_SATURATE_EN` defined: the shifted accumulator is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- `FIR_SATURATE_EN` undefined: the low DATA_WIDTH bits of the shifted accumulator are output (wrap).
- Both builds have identical cycle timing.

## Test plan
- **Ramp**: h[k]=1<<16 for all k, x[i]=i, `y_ready`=1.
  - Required: y[0]=0, y[1]=1, y[3]=6, y[15]=120, y[20]=200, y[63]=888.
  - First `y_valid` 18 cycles after the `start` sample cycle.
- **Impulse**: x[0]=1<<16, x[i≠0]=0, h[k]=k+1.
  - Required: y[n]=n+1 for n<16, y[n]=0 for n≥16.
  - `R_en` low on every k>n cycle.
- **Backpressure**: ramp data with `y_ready` held low for 5 cycles at n=3.
  - Required: `y_out`=6 and `y_index`=3 stable throughout; n=4 FETCH starts the cycle after acceptance.
- **Overflow**: h[0]=x[0]=0x7FFFFFFF, other entries 0.
  - Required: y[0]=0x7FFFFFFF with `FIR_SATURATE_EN` defined; y[0]=0xFFFF0000 without it.
- **Reset mid-pass**: assert `rst_n`=1 during FETCH of n=5 at k=7.
  - Required: all outputs 0 asynchronously, FSM in IDLE.
  - After release plus `start`, the pass restarts at n=0 with correct y[0].
- **Control**: `start` pulsed while `busy`=1 has no effect. `done` pulses exactly once per pass, one cycle after y[63] is accepted.
